bcd_subtractor_seq: RTL

//  Digit-serial multi-digit BCD subtractor, the inverse companion of the BCD adder digit.

---
 rtl/bcd_subtractor_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_subtractor_seq.sv
// Digit-serial BCD subtractor: diff = |a - b| in packed BCD, neg = (a < b), LSD first.
// Latency: DIGITS cycles accept->done (a >= b), 2*DIGITS (a < b), 1 with invalid digits under check.
// Backpressure: start is honoured only in IDLE; start while busy or during done is ignored.
//
// Ports: clk, rst (sync, active-high); start request; a/b packed BCD operands (digit 0 = [3:0]);
//        busy (operation in flight), done (1-cycle result strobe), diff/neg/err held until next accept.
// Optional build macro BCD_SUB_CHECK_EN: flags operand digits > 9 at capture (err=1, immediate done).
//   Without it err is tied low and invalid digits just flow through the arithmetic.
module bcd_subtractor_seq #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] diff,
   output logic                neg,
   output logic                err
);

   localparam int         W    = 4 * DIGITS;
   localparam logic [3:0] LAST = 4'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

   state_t       state, state_nx;
   logic [W-1:0] ar, br;        // captured operands, shifted right one digit per SUB cycle
   logic         borrow;
   logic [3:0]   idx;
   logic         last;
   logic         bad;
   logic [3:0]   dx, dy, dres;
   logic [4:0]   t;
   logic         bo;
   logic [W+3:0] diff_cat;
   logic [W-1:0] diff_sh;

`ifdef BCD_SUB_CHECK_EN
   function automatic logic has_bad_digit(input logic [W-1:0] x);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (x[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction
   assign bad = has_bad_digit(a) | has_bad_digit(b);
`else
   assign bad = 1'b0;
`endif

   // One digit of subtraction. In FIX the minuend is 0 and the subtrahend is the
   // stored result digit, which ten's-complements the result as it rotates through.
   always_comb begin
      dx   = (state == FIX) ? 4'd0 : ar[3:0];
      dy   = (state == FIX) ? diff[3:0] : br[3:0];
      t    = {1'b0, dx} - {1'b0, dy} - {4'd0, borrow};
      bo   = t[4];
      dres = bo ? (t[3:0] + 4'd10) : t[3:0];
      last = (idx == LAST);
      // Result digits enter at the top and shift down; after DIGITS steps they sit in place.
      diff_cat = {dres, diff};
      diff_sh  = diff_cat[W+3:4];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = bad ? DONE : SUB;
         SUB:  if (last)  state_nx = bo ? FIX : DONE;
         FIX:  if (last)  state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == SUB) || (state == FIX);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         ar     <= '0;
         br     <= '0;
         diff   <= '0;
         neg    <= 1'b0;
         borrow <= 1'b0;
         idx    <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ar     <= a;
                  br     <= b;
                  diff   <= '0;
                  neg    <= 1'b0;
                  borrow <= 1'b0;
                  idx    <= 4'd0;
               end
            end
            SUB: begin
               ar     <= ar >> 4;
               br     <= br >> 4;
               diff   <= diff_sh;
               borrow <= bo;
               idx    <= idx + 4'd1;
               if (last) begin
                  // FIX pass starts from a clean borrow.
                  borrow <= 1'b0;
                  idx    <= 4'd0;
               end
            end
            FIX: begin
               diff   <= diff_sh;
               borrow <= bo;
               idx    <= idx + 4'd1;
               if (last) begin
                  neg    <= 1'b1;
                  borrow <= 1'b0;
                  idx    <= 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BCD_SUB_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)                         err <= 1'b0;
      else if (state == IDLE && start) err <= bad;
   end
`else
   assign err = 1'b0;
`endif

endmodule
